// File: rtl/reg_bus_master.sv
// reg_bus_master: host burst command -> byte-serial register bus initiator.
// Ports:
//   clk_usb, reset_i                  clock, sync active-high reset
//   cmd_valid/ready/write/addr/len    burst command (len 0 = no bus activity)
//   wdata/_valid/_ready               write byte stream into the bus
//   rdata/_valid/_ready               read byte stream out of the bus
//   reg_address/bytecnt/datai         bus address, byte index, write data
//   reg_write, reg_read               write strobe, read qualifier
//   reg_datao                         OR of all responders' read data
//   busy                              burst in progress
module reg_bus_master #(
  parameter int pBYTECNT_SIZE = 7,
  parameter int pREAD_LATENCY = 1
) (
  input  logic                     clk_usb,
  input  logic                     reset_i,
  input  logic                     cmd_valid,
  output logic                     cmd_ready,
  input  logic                     cmd_write,
  input  logic [7:0]               cmd_addr,
  input  logic [pBYTECNT_SIZE-1:0] cmd_len,
  input  logic [7:0]               wdata,
  input  logic                     wdata_valid,
  output logic                     wdata_ready,
  output logic [7:0]               rdata,
  output logic                     rdata_valid,
  input  logic                     rdata_ready,
  output logic [7:0]               reg_address,
  output logic [pBYTECNT_SIZE-1:0] reg_bytecnt,
  output logic [7:0]               reg_datai,
  output logic                     reg_write,
  output logic                     reg_read,
  input  logic [7:0]               reg_datao,
  output logic                     busy
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_WR_WAIT,
    S_WR_STROBE,
    S_RD_SETUP,
    S_RD_WAIT,
    S_RD_HOLD,
    S_DONE
  } state_t;

  localparam logic [pBYTECNT_SIZE-1:0] BC_ONE = 1;
  localparam logic [2:0] WAIT_INIT = 3'(pREAD_LATENCY - 1);

  state_t                   state;
  logic [pBYTECNT_SIZE-1:0] len_q;
  logic [2:0]               wait_cnt;
  logic                     last;

  assign last = (reg_bytecnt == len_q - BC_ONE);

  always_ff @(posedge clk_usb) begin
    if (reset_i) begin
      state       <= S_IDLE;
      len_q       <= '0;
      wait_cnt    <= '0;
      cmd_ready   <= 1'b0;
      wdata_ready <= 1'b0;
      rdata       <= '0;
      rdata_valid <= 1'b0;
      reg_address <= '0;
      reg_bytecnt <= '0;
      reg_datai   <= '0;
      reg_write   <= 1'b0;
      reg_read    <= 1'b0;
      busy        <= 1'b0;
    end else begin
      unique case (state)
        S_IDLE: begin
          if (cmd_valid && cmd_ready) begin
            cmd_ready   <= 1'b0;
            busy        <= 1'b1;
            reg_address <= cmd_addr;
            reg_bytecnt <= '0;
            len_q       <= cmd_len;
            if (cmd_len == '0) begin
              state <= S_DONE;
            end else if (cmd_write) begin
              state       <= S_WR_WAIT;
              wdata_ready <= 1'b1;
            end else begin
              state    <= S_RD_SETUP;
              reg_read <= 1'b1;
            end
          end else begin
            // first cycle out of reset
            cmd_ready <= 1'b1;
          end
        end
        S_WR_WAIT: begin
          if (wdata_valid) begin
            reg_datai   <= wdata;
            wdata_ready <= 1'b0;
            reg_write   <= 1'b1;
            state       <= S_WR_STROBE;
          end
        end
        S_WR_STROBE: begin
          reg_write <= 1'b0;
          if (last) begin
            busy  <= 1'b0;
            state <= S_DONE;
          end else begin
            reg_bytecnt <= reg_bytecnt + BC_ONE;
            wdata_ready <= 1'b1;
            state       <= S_WR_WAIT;
          end
        end
        S_RD_SETUP: begin
          wait_cnt <= WAIT_INIT;
          state    <= S_RD_WAIT;
        end
        S_RD_WAIT: begin
          if (wait_cnt == '0) begin
            rdata       <= reg_datao;
            rdata_valid <= 1'b1;
            state       <= S_RD_HOLD;
          end else begin
            wait_cnt <= wait_cnt - 3'd1;
          end
        end
        S_RD_HOLD: begin
          if (rdata_ready) begin
            rdata_valid <= 1'b0;
            if (last) begin
              reg_read <= 1'b0;
              busy     <= 1'b0;
              state    <= S_DONE;
            end else begin
              reg_bytecnt <= reg_bytecnt + BC_ONE;
              state       <= S_RD_SETUP;
            end
          end
        end
        S_DONE: begin
          // zero-length bursts still hold busy until here
          busy      <= 1'b0;
          cmd_ready <= 1'b1;
          state     <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule
